// File: rtl/lut_neuron_rr_sched_pkg.sv
// Shared constants, types and helpers for the time-multiplexed LUT neuron scheduler.
package lut_sched_pkg;

    localparam int LUT_IN_W  = 6;
    localparam int LUT_OUT_W = 2;
    // Widest requester tag supported (NUM_REQ up to 16).
    localparam int MAX_ID_W  = 4;

    // $clog2 that never returns 0, so a tag field always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        if (n <= 2) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

    // Saturating 16-bit increment for statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Contents of the output (capture) stage.
    typedef struct packed {
        logic [LUT_OUT_W-1:0] data;
        logic [MAX_ID_W-1:0]  id;
    } lut_rsp_t;

endpackage

// File: rtl/lut_neuron_rr_sched_if.sv
// Request/response handshake bundle between producers, the scheduler and the next layer.
interface lut_neuron_rr_sched_if
    import lut_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = LUT_IN_W,
    parameter int OUT_W   = LUT_OUT_W
);
    localparam int ID_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic [OUT_W-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_ready;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/lut_neuron_rr_sched_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_rr_ptr, with wrap.
module lut_rr_arbiter
    import lut_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_grant
);

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        j           = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_rr_ptr) + k >= NUM_REQ) ? (int'(i_rr_ptr) + k - NUM_REQ)
                                                 : (int'(i_rr_ptr) + k);
            if (i_en && !o_any_grant && i_req[j]) begin
                o_any_grant = 1'b1;
                o_grant_idx = ID_W'(j);
                o_grant[j]  = 1'b1;
            end else begin
                o_any_grant = o_any_grant;
            end
        end
    end

endmodule

// File: rtl/lut_neuron_rr_sched.sv
// Shares one external combinational LUT neuron between NUM_REQ requesters through a
// round-robin arbiter and a two-stage (issue, capture) pipeline.
// Optional statistics counters: define LUT_NEURON_RR_SCHED_STATS_EN.
module lut_neuron_rr_sched
    import lut_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = LUT_IN_W,
    parameter int OUT_W   = LUT_OUT_W,
    localparam int ID_W   = clog2_min1(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
`ifdef LUT_NEURON_RR_SCHED_STATS_EN
    input  logic                     i_stat_clr,
    output logic [NUM_REQ*16-1:0]    o_stat_grants,
    output logic [15:0]              o_stat_stalls,
`endif
    lut_neuron_rr_sched_if.slave     bus,
    output logic [IN_W-1:0]          o_lut_in,
    input  logic [OUT_W-1:0]         i_lut_out,
    output logic                     o_busy
);

    logic              r_v1;
    logic              r_v2;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [IN_W-1:0]   r_lut_in;
    logic [ID_W-1:0]   r_id1;
    lut_rsp_t          r_s2;

    logic              w_adv1;
    logic              w_adv2;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]   w_gidx;
    logic              w_any;

    // S2 can take new data when empty or when the consumer drains it; S1 likewise via S2.
    assign w_adv2 = !r_v2 || bus.rsp_ready;
    assign w_adv1 = !r_v1 || w_adv2;

    lut_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req       (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_en        (w_adv1 && !i_rst),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any_grant (w_any)
    );

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_v2;
    assign bus.rsp_data  = r_s2.data;
    assign bus.rsp_id    = r_s2.id[ID_W-1:0];
    assign o_lut_in      = r_lut_in;
    assign o_busy        = r_v1 || r_v2;

    // Capture stage: samples the LUT result while lut_in is held stable by S1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_adv2) begin
            r_v2      <= r_v1;
            r_s2.data <= i_lut_out;
            r_s2.id   <= MAX_ID_W'(r_id1);
        end
    end

    // Issue stage: latches the granted request vector onto the LUT input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_lut_in <= '0;
            r_id1    <= '0;
        end else if (w_adv1) begin
            r_v1 <= w_any;
            if (w_any) begin
                r_lut_in <= bus.req_data[int'(w_gidx)*IN_W +: IN_W];
                r_id1    <= w_gidx;
            end
        end
    end

    // Round-robin pointer moves to the requester after the last winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_gidx == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : (w_gidx + ID_W'(1));
        end
    end

`ifdef LUT_NEURON_RR_SCHED_STATS_EN
    logic [15:0] r_stat_grants [NUM_REQ];
    logic [15:0] r_stat_stalls;

    // Per-requester grant counts and output-stall cycle count, both saturating.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_grants[i] <= 16'd0;
            end
            r_stat_stalls <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_stat_grants[i] <= sat_inc16(r_stat_grants[i]);
                end
            end
            if (r_v2 && !bus.rsp_ready) begin
                r_stat_stalls <= sat_inc16(r_stat_stalls);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_pack
        assign o_stat_grants[gi*16 +: 16] = r_stat_grants[gi];
    end
    assign o_stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_lut_neuron_rr_sched.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// literal checks for the reset state, latency, ordering, backpressure and reset flush.
module tb_lut_neuron_rr_sched;

    localparam int N  = 4;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    logic [IW-1:0] w_lut_in;
    logic [1:0]    w_lut_out;
    logic          w_busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    lut_neuron_rr_sched_if bus ();

`ifdef LUT_NEURON_RR_SCHED_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_grants;
    logic [15:0] stat_stalls;
`endif

    lut_neuron_rr_sched dut (
        .i_clk        (clk),
        .i_rst        (rst),
`ifdef LUT_NEURON_RR_SCHED_STATS_EN
        .i_stat_clr   (stat_clr),
        .o_stat_grants(stat_grants),
        .o_stat_stalls(stat_stalls),
`endif
        .bus          (bus),
        .o_lut_in     (w_lut_in),
        .i_lut_out    (w_lut_out),
        .o_busy       (w_busy)
    );

    // Stand-in neuron table; maps 6'b010000 to 2'b11.
    function automatic logic [1:0] lut_fn(input logic [5:0] x);
        return {x[4] | x[0], x[4] ^ x[3] ^ x[1]};
    endfunction

    assign w_lut_out = lut_fn(w_lut_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: in-flight items in grant order; an item may appear at the
    // output two cycles after its accept, and at most two items can be in flight.
    typedef struct {
        logic [1:0] d;
        int         id;
        int         rc;
    } item_t;
    item_t q[$];
    int    m_rr = 0;
    bit    live = 1'b0;

    always @(negedge clk) begin
        bit         adv;
        bit         ev;
        int         g;
        logic [3:0] er;
        adv = (q.size() < 2) || bus.rsp_ready;
        g   = -1;
        if (adv && !rst) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        ev = (q.size() > 0) && (q[0].rc <= cyc);
        if (live) begin
            chk("m_req_ready", 32'(bus.req_ready), 32'(er));
            chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            chk("m_busy", 32'(w_busy), 32'(q.size() > 0));
            if (ev) begin
                chk("m_rsp_data", 32'(bus.rsp_data), 32'(q[0].d));
                chk("m_rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            end
        end
        if (rst) begin
            q.delete();
            m_rr = 0;
            live = 1'b1;
        end else begin
            if (ev && bus.rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(item_t'{d: lut_fn(bus.req_data[g*IW +: IW]), id: g, rc: cyc + 2});
                m_rr = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int         acc;
        logic [1:0] held;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
`ifdef LUT_NEURON_RR_SCHED_STATS_EN
        stat_clr      = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        at_neg();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(w_busy), 32'd0);
        chk("rst_lut_in", 32'(w_lut_in), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);

        // Single request: accept at t, response at t+2.
        tick();
        bus.req_valid = 4'b0001;
        bus.req_data  = 24'h000010;
        at_neg();
        chk("single_accept", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        at_neg();
        chk("single_t1_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        at_neg();
        chk("single_t2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_t2_data", 32'(bus.rsp_data), 32'h3);
        chk("single_t2_id", 32'(bus.rsp_id), 32'd0);

        // Full load: pointer sits at 1, so grants rotate 1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            tick();
            bus.req_valid = 4'b1111;
            bus.req_data  = 24'($urandom);
            at_neg();
            chk("rr_full", 32'(bus.req_ready), 32'(4'b0001 << ((1 + k) % 4)));
        end
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        repeat (3) tick();

        // Sparse: pointer at 2, only 1 and 3 valid -> 3 then 1.
        bus.req_valid = 4'b1010;
        at_neg();
        chk("sparse_first", 32'(bus.req_ready), 32'h8);
        tick();
        at_neg();
        chk("sparse_second", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0000;
        repeat (3) tick();

        // Backpressure: two accepts, then blocked; held output stays stable.
        bus.rsp_ready = 1'b0;
        acc = 0;
        held = 2'b00;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 4'b1111;
            bus.req_data  = 24'($urandom);
            at_neg();
            if (bus.req_ready != 4'b0000) acc++;
            if (k == 2) held = bus.rsp_data;
            if (k >= 3) chk("bp_hold_data", 32'(bus.rsp_data), 32'(held));
            tick();
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0000;
        repeat (4) tick();

        // Reset with both stages full drops the work.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0110;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_mid_busy", 32'(w_busy), 32'd0);
            tick();
        end
        bus.req_valid = 4'b1111;
        at_neg();
        chk("rst_mid_ptr0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        repeat (3) tick();

`ifdef LUT_NEURON_RR_SCHED_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.req_valid = 4'b0100;
        repeat (10) tick();
        bus.req_valid = 4'b0000;
        repeat (3) tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        repeat (4) tick();
        bus.rsp_ready = 1'b1;
        at_neg();
        chk("stat_grants2", 32'(stat_grants[2*16 +: 16]), 32'd10);
        chk("stat_stalls", 32'(stat_stalls), 32'd3);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        at_neg();
        chk("stat_clr_grants", 32'(stat_grants != 64'd0), 32'd0);
        chk("stat_clr_stalls", 32'(stat_stalls), 32'd0);
        tick();
`endif

        // Random traffic with occasional resets, checked by the model.
        for (int k = 0; k < 1500; k++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.req_valid = 4'($urandom);
            bus.req_data  = 24'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst           = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
